// File: rtl/mem_responder_if.sv
// Controller-to-memory request/response bundle: per-channel valid/ready read and
// write channels. The controller is the master, the memory model is the slave.
interface mem_responder_if #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 1
);
    logic [NUM_CHANNELS-1:0]                mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
    logic [NUM_CHANNELS-1:0]                mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
    logic [NUM_CHANNELS-1:0]                mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
    logic [NUM_CHANNELS-1:0]                mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/mem_responder.sv
// Multi-channel global-memory model with fixed read/write latency and a side
// preload port; each channel runs an independent request FSM.
module mem_responder #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CHANNELS  = 1,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2,
    parameter bit WRITE_ENABLE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_responder_if.slave       bus,
    input  logic                 load_valid,
    input  logic [ADDR_BITS-1:0] load_address,
    input  logic [DATA_BITS-1:0] load_data
);
    localparam int DEPTH    = 1 << ADDR_BITS;
    localparam int LAT_MAX  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_BITS = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CNT_BITS-1:0] RD_LOAD = CNT_BITS'(READ_LATENCY - 1);
    localparam logic [CNT_BITS-1:0] WR_LOAD = CNT_BITS'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ_BUSY,
        WRITE_BUSY,
        RESPOND,
        RELEASE
    } state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];

    state_t               state_q [NUM_CHANNELS];
    state_t               state_d [NUM_CHANNELS];
    logic [CNT_BITS-1:0]  cnt_q   [NUM_CHANNELS];
    logic [CNT_BITS-1:0]  cnt_d   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr_q  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] addr_d  [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wdata_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wdata_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] rd_fire;
    logic [NUM_CHANNELS-1:0] wr_fire;

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            addr_d[i]  = addr_q[i];
            wdata_d[i] = wdata_q[i];
            rd_fire[i] = 1'b0;
            wr_fire[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (bus.mem_read_valid[i]) begin
                        addr_d[i]  = bus.mem_read_address[i];
                        cnt_d[i]   = RD_LOAD;
                        state_d[i] = READ_BUSY;
                    end else if (bus.mem_write_valid[i] && WRITE_ENABLE) begin
                        addr_d[i]  = bus.mem_write_address[i];
                        wdata_d[i] = bus.mem_write_data[i];
                        cnt_d[i]   = WR_LOAD;
                        state_d[i] = WRITE_BUSY;
                    end
                end
                READ_BUSY: begin
                    if (cnt_q[i] == '0) begin
                        rd_fire[i] = 1'b1;
                        state_d[i] = RESPOND;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
                WRITE_BUSY: begin
                    if (cnt_q[i] == '0) begin
                        wr_fire[i] = 1'b1;
                        state_d[i] = RESPOND;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                end
                RESPOND: state_d[i] = RELEASE;
                // Wait for the controller to drop its valid so a request is served once.
                RELEASE: begin
                    if (!bus.mem_read_valid[i] && !bus.mem_write_valid[i]) begin
                        state_d[i] = IDLE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i]             <= IDLE;
                cnt_q[i]               <= '0;
                addr_q[i]              <= '0;
                wdata_q[i]             <= '0;
                bus.mem_read_ready[i]  <= 1'b0;
                bus.mem_write_ready[i] <= 1'b0;
                bus.mem_read_data[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i]             <= state_d[i];
                cnt_q[i]               <= cnt_d[i];
                addr_q[i]              <= addr_d[i];
                wdata_q[i]             <= wdata_d[i];
                // Ready is high only for the cycle after the exit edge, i.e. cleared in RESPOND.
                bus.mem_read_ready[i]  <= rd_fire[i];
                bus.mem_write_ready[i] <= wr_fire[i];
                if (rd_fire[i]) begin
                    bus.mem_read_data[i] <= mem[addr_q[i]];
                end
            end
        end
    end

    // NOTE: the array is reset word by word because the model must start from all zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            // Later assignments win: load first, then channels in ascending index order.
            if (load_valid) begin
                mem[load_address] <= load_data;
            end
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (wr_fire[i]) begin
                    mem[addr_q[i]] <= wdata_q[i];
                end
            end
        end
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-channel global-memory model with a fixed, programmable access latency. It answers the controller's per-channel valid/ready read and write channels, so it is the responder at the memory side of the controller-to-memory interface. It holds a 2^ADDR_BITS-word array and has a side load port for program and data preload. Instances serve as program memory (writes disabled) or data memory, in the simulation top level and on FPGA builds.

## Interface
- ADDR_BITS, 8, address width; array depth is 2^ADDR_BITS words
- DATA_BITS, 16, word width
- NUM_CHANNELS, 1, number of independent request channels
- READ_LATENCY, 2, cycles from request acceptance to mem_read_ready; must be ≥1
- WRITE_LATENCY, 2, cycles from request acceptance to mem_write_ready; must be ≥1
- WRITE_ENABLE, 1, 0 means channel writes are never accepted (program memory)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- mem_read_valid  in  [NUM_CHANNELS]  read request per channel; held high with a stable address until ready is seen
- mem_read_address  in  [NUM_CHANNELS] x ADDR_BITS  read address
- mem_read_ready  out  [NUM_CHANNELS]  one-cycle pulse: read data is valid
- mem_read_data  out  [NUM_CHANNELS] x DATA_BITS  read data; holds its value until the next read completes
- mem_write_valid  in  [NUM_CHANNELS]  write request per channel
- mem_write_address  in  [NUM_CHANNELS] x ADDR_BITS  write address
- mem_write_data  in  [NUM_CHANNELS] x DATA_BITS  write data
- mem_write_ready  out  [NUM_CHANNELS]  one-cycle pulse: write committed
- load_valid  in  1  preload strobe; writes regardless of WRITE_ENABLE
- load_address  in  ADDR_BITS  preload address
- load_data  in  DATA_BITS  preload data

## Operation
- Reset (reset=0, asynchronous): all array words, mem_read_data and counters are set to 0; mem_read_ready and mem_write_ready are 0; every channel state is IDLE.
- Each channel has its own FSM: IDLE, READ_BUSY, WRITE_BUSY, RESPOND, RELEASE. Each channel also has a latency counter, a captured address and captured write data.
- IDLE:
  - if mem_read_valid[i]=1: capture the address, load the counter with READ_LATENCY-1, go to READ_BUSY.
  - else if mem_write_valid[i]=1 and WRITE_ENABLE=1: capture the address and data, load the counter with WRITE_LATENCY-1, go to WRITE_BUSY.
  - Read wins when both valids are high; the write is served after RELEASE if its valid is still high.
- READ_BUSY / WRITE_BUSY: if the counter is 0, go to RESPOND; otherwise decrement the counter.
  - On the READ_BUSY exit edge: mem_read_data[i] <= array[addr] and mem_read_ready[i] <= 1.
  - On the WRITE_BUSY exit edge: array[addr] <= data and mem_write_ready[i] <= 1.
- RESPOND (lasts exactly one cycle): clear the ready, go to RELEASE. The request valid is still high on this edge because the controller drops it on the same edge it sees ready.
- RELEASE: go to IDLE once both valids of the channel are sampled low. The same request is never served twice.
- Array writes from several sources on the same edge: the highest channel index wins, and any channel write beats load_valid.
- A read capturing on the same edge as a write to the same address returns the old data (read-before-write).
- Addresses wrap naturally within ADDR_BITS; there are no out-of-range cases.
- If valid drops during BUSY (protocol violation), the access still completes and ready still pulses.
- With WRITE_ENABLE=0, a write-only request leaves the channel in IDLE forever and mem_write_ready stays 0.

## Timing
- A request is accepted on edge e0 (valid high, state IDLE). Ready is visible after edge e0+LATENCY and stays high for exactly 1 cycle.
- The controller raises valid on edge t and sees ready on edge t+2+LATENCY.
- The channel is back in IDLE at the earliest 2 cycles after ready rises. Minimum request-to-request period per channel: LATENCY+3 cycles.
- Channels are fully independent; there is no arbitration stall.
- A preload commits on the edge where load_valid=1 and is readable by a channel read captured on the next edge.

## Test plan
- Reset: drive reset=0 mid-read → ready is 0 immediately (asynchronous); after release, mem_read_data=0 and all channels are IDLE.
- Preload then read: load addr 0x10=0xBEEF, READ_LATENCY=2, hold valid with address 0x10 → mem_read_ready pulses 1 cycle, 2 cycles after acceptance, data=0xBEEF; no second pulse while valid is still high on the RESPOND edge.
- Write then read: write 0x1234 to 0x05 → write_ready pulses; a subsequent read of 0x05 returns 0x1234. With WRITE_ENABLE=0: no write_ready, array unchanged.
- Collision: NUM_CHANNELS=2, both channels write address 0x20 (0xAAAA on ch0, 0x5555 on ch1) committing on the same edge → a later read of 0x20 returns 0x5555.
- Read-before-write: ch0 reads 0x30 (old value 0x0001) while ch1 writes 0x0002 to 0x30 on the same edge → ch0 gets 0x0001; a later read gets 0x0002.
- Back-to-back: 4 reads on one channel with valid dropped one cycle after each ready → each completes in LATENCY+3 cycles with no lost or duplicated ready pulses.
